// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU and the debug port.
// Ports: C_* CPU port, D_* debug port (D_LOCK = burst lock), M_* memory side.
// The optional fair mode is enabled with the macro DMEM_ARB_FAIR_EN.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                C_REQ,
  input  logic [DATA_W/8-1:0] C_WE,
  input  logic [ADDR_W-1:0]   C_ADDR,
  input  logic [DATA_W-1:0]   C_WDATA,
  output logic                C_GNT,
  output logic                C_RVALID,
  output logic [DATA_W-1:0]   C_RDATA,
  input  logic                D_REQ,
  input  logic [DATA_W/8-1:0] D_WE,
  input  logic [ADDR_W-1:0]   D_ADDR,
  input  logic [DATA_W-1:0]   D_WDATA,
  output logic                D_GNT,
  output logic                D_RVALID,
  output logic [DATA_W-1:0]   D_RDATA,
  input  logic                D_LOCK,
  output logic [ADDR_W-1:0]   M_ADDR,
  output logic [DATA_W/8-1:0] M_WE,
  output logic                M_RE,
  output logic [DATA_W-1:0]   M_WDATA,
  input  logic [DATA_W-1:0]   M_RDATA
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU,
    S_DBG,
    S_DBG_LOCKED
  } state_e;

  state_e              state_q;
  logic                pend_q;
  logic                own_q;
  logic [ADDR_W-1:0]   maddr_q;
  logic [DATA_W-1:0]   mwdata_q;
  logic [DATA_W-1:0]   c_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                locked;
  logic                starve_hit;
  logic                d_own;

  assign locked = (state_q == S_DBG_LOCKED);

`ifdef DMEM_ARB_FAIR_EN
  logic [7:0] starve_q;

  assign starve_hit = (starve_q == 8'(STARVE_LIMIT));

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      starve_q <= '0;
    end else if (D_GNT || !D_REQ) begin
      starve_q <= '0;
    end else if (C_GNT && starve_q != 8'hFF) begin
      starve_q <= starve_q + 8'd1;
    end
  end
`else
  logic unused_limit;

  assign unused_limit = ^32'(STARVE_LIMIT);
  assign starve_hit   = 1'b0;
`endif

  // Grants are gated by reset so nothing reaches memory while held.
  assign C_GNT = RSTN & ~locked & C_REQ & ~(D_REQ & starve_hit);
  assign D_GNT = RSTN & D_REQ & ~C_GNT;

  // While locked the debug port owns the memory even when idle.
  assign d_own = D_GNT | locked;

  always_comb begin
    M_ADDR  = maddr_q;
    M_WDATA = mwdata_q;
    M_WE    = '0;
    M_RE    = 1'b0;
    if (C_GNT) begin
      M_ADDR  = C_ADDR;
      M_WDATA = C_WDATA;
      M_WE    = C_WE;
      M_RE    = (C_WE == '0);
    end else if (D_GNT) begin
      M_ADDR  = D_ADDR;
      M_WDATA = D_WDATA;
      M_WE    = D_WE;
      M_RE    = (D_WE == '0);
    end
  end

  // A read in flight when reset hits is dropped.
  assign C_RVALID = RSTN & pend_q & ~own_q;
  assign D_RVALID = RSTN & pend_q & own_q;
  assign C_RDATA  = C_RVALID ? M_RDATA : c_rdata_q;
  assign D_RDATA  = D_RVALID ? M_RDATA : d_rdata_q;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      own_q     <= 1'b0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      unique case (1'b1)
        d_own:   state_q <= D_LOCK ? S_DBG_LOCKED : S_DBG;
        C_GNT:   state_q <= S_CPU;
        default: state_q <= state_q;
      endcase
      pend_q    <= M_RE;
      own_q     <= D_GNT;
      maddr_q   <= M_ADDR;
      mwdata_q  <= M_WDATA;
      c_rdata_q <= C_RDATA;
      d_rdata_q <= D_RDATA;
    end
  end

endmodule
